// File: rtl/lrr_arbiter_n_if.sv
// Handshake bundle for lrr_arbiter_n: N_IN ready/valid inputs merged onto one output.
// The master modport is the traffic side; the slave modport is the arbiter.
interface lrr_arbiter_n_if #(
  parameter int N_IN   = 4,
  parameter int DATA_W = 64,
  parameter int CW     = (N_IN > 1) ? $clog2(N_IN) : 1
) ();
  logic [N_IN-1:0]        in_valid;
  logic [N_IN-1:0]        in_ready;
  logic [N_IN*DATA_W-1:0] in_data;
  logic [N_IN-1:0]        in_multibeat;
  logic                   out_valid;
  logic                   out_ready;
  logic [DATA_W-1:0]      out_data;
  logic                   out_multibeat;
  logic [CW-1:0]          out_chosen;
  logic                   out_locked;

  modport master (
    output in_valid, in_data, in_multibeat, out_ready,
    input  in_ready, out_valid, out_data, out_multibeat, out_chosen, out_locked
  );

  modport slave (
    input  in_valid, in_data, in_multibeat, out_ready,
    output in_ready, out_valid, out_data, out_multibeat, out_chosen, out_locked
  );
endinterface

// File: rtl/lrr_arbiter_n.sv
// Locking round-robin arbiter: a multibeat burst holds the grant for BEATS fires.
// Optional output register slice: define LRR_ARB_OUT_REG_EN.
module lrr_arbiter_n #(
  parameter int N_IN   = 4,
  parameter int DATA_W = 64,
  parameter int BEATS  = 8,
  parameter int CW     = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic           clk,
  input  logic           reset,
  lrr_arbiter_n_if.slave bus
);
  localparam int              LCW       = $clog2(BEATS) + 1;
  localparam logic [CW-1:0]   LAST_CH   = CW'(N_IN - 1);
  localparam logic [LCW-1:0]  LAST_BEAT = LCW'(BEATS - 1);

  logic [LCW-1:0]    lock_cnt_q, lock_cnt_d;
  logic [CW-1:0]     lock_idx_q, lock_idx_d;
  logic [CW-1:0]     last_grant_q, last_grant_d;
  logic [CW-1:0]     rr_choice, mux_chosen;
  logic [CW-1:0]     hi_idx, lo_idx;
  logic              hi_found, lo_found;
  logic              locked;
  logic              mux_valid, mux_multibeat, mux_ready, mux_fire;
  logic [DATA_W-1:0] mux_data;

  assign locked = (lock_cnt_q != '0);

  // Round robin: first valid above last_grant, else wrap to the lowest valid.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (bus.in_valid[i] && !lo_found) begin
        lo_found = 1'b1;
        lo_idx   = CW'(i);
      end
      if (bus.in_valid[i] && !hi_found && (CW'(i) > last_grant_q)) begin
        hi_found = 1'b1;
        hi_idx   = CW'(i);
      end
    end
    if (hi_found)      rr_choice = hi_idx;
    else if (lo_found) rr_choice = lo_idx;
    else               rr_choice = LAST_CH;
  end

  assign mux_chosen = locked ? lock_idx_q : rr_choice;

  always_comb begin
    mux_valid     = 1'b0;
    mux_multibeat = 1'b0;
    mux_data      = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (mux_chosen == CW'(i)) begin
        mux_valid     = bus.in_valid[i];
        mux_multibeat = bus.in_multibeat[i];
        mux_data      = bus.in_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    bus.in_ready = '0;
    for (int i = 0; i < N_IN; i++)
      bus.in_ready[i] = mux_ready && (mux_chosen == CW'(i));
  end

  assign mux_fire = mux_valid && mux_ready;

  // A flag-low fire mid-burst still moves last_grant but not the count.
  always_comb begin
    lock_cnt_d   = lock_cnt_q;
    lock_idx_d   = lock_idx_q;
    last_grant_d = last_grant_q;
    if (mux_fire) begin
      last_grant_d = mux_chosen;
      if (mux_multibeat) begin
        if (lock_cnt_q == '0) begin
          lock_cnt_d = LCW'(1);
          lock_idx_d = mux_chosen;
        end else if (lock_cnt_q == LAST_BEAT) begin
          lock_cnt_d = '0;
        end else begin
          lock_cnt_d = lock_cnt_q + LCW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_cnt_q   <= '0;
      lock_idx_q   <= '0;
      last_grant_q <= LAST_CH;
    end else begin
      lock_cnt_q   <= lock_cnt_d;
      lock_idx_q   <= lock_idx_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign bus.out_locked = locked;

`ifdef LRR_ARB_OUT_REG_EN
  logic              slice_vld_q, slice_vld_d;
  logic              slice_mb_q, slice_mb_d;
  logic [CW-1:0]     slice_chosen_q, slice_chosen_d;
  logic [DATA_W-1:0] slice_data_q, slice_data_d;

  // Slice accepts whenever it is empty or draining this cycle.
  assign mux_ready = !slice_vld_q || bus.out_ready;

  always_comb begin
    slice_vld_d    = slice_vld_q;
    slice_mb_d     = slice_mb_q;
    slice_chosen_d = slice_chosen_q;
    slice_data_d   = slice_data_q;
    if (mux_fire) begin
      slice_vld_d    = 1'b1;
      slice_mb_d     = mux_multibeat;
      slice_chosen_d = mux_chosen;
      slice_data_d   = mux_data;
    end else if (bus.out_ready) begin
      slice_vld_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slice_vld_q    <= 1'b0;
      slice_mb_q     <= 1'b0;
      slice_chosen_q <= '0;
      slice_data_q   <= '0;
    end else begin
      slice_vld_q    <= slice_vld_d;
      slice_mb_q     <= slice_mb_d;
      slice_chosen_q <= slice_chosen_d;
      slice_data_q   <= slice_data_d;
    end
  end

  assign bus.out_valid     = slice_vld_q;
  assign bus.out_multibeat = slice_mb_q;
  assign bus.out_chosen    = slice_chosen_q;
  assign bus.out_data      = slice_data_q;
`else
  assign mux_ready         = bus.out_ready;
  assign bus.out_valid     = mux_valid;
  assign bus.out_multibeat = mux_multibeat;
  assign bus.out_chosen    = mux_chosen;
  assign bus.out_data      = mux_data;
`endif
endmodule

// File: tb/tb_lrr_arbiter_n.sv
// Bench for lrr_arbiter_n (N_IN=4, BEATS=8): vector table through a scoreboard queue,
// plus a toggling-ready ordering run when LRR_ARB_OUT_REG_EN is defined.
module tb_lrr_arbiter_n;
  localparam int N_IN = 4, DATA_W = 64, BEATS = 8, CW = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lrr_arbiter_n_if #(.N_IN(N_IN), .DATA_W(DATA_W), .CW(CW)) bus ();

  lrr_arbiter_n #(.N_IN(N_IN), .DATA_W(DATA_W), .BEATS(BEATS), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic       rst;
    logic [3:0] vld;
    logic [3:0] mb;
    logic       rdy;
    logic [1:0] ch;
    logic       v;
    logic [3:0] rexp;
    logic       lk;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic rst, input logic [3:0] vld, input logic [3:0] mb,
                              input logic rdy, input logic [1:0] ch, input logic v,
                              input logic lk);
    vec_t r;
    r.rst = rst; r.vld = vld; r.mb = mb; r.rdy = rdy;
    r.ch = ch; r.v = v; r.lk = lk;
    r.rexp = rdy ? (4'b0001 << ch) : 4'b0000;
    vecs.push_back(r);
  endfunction

  function automatic logic [63:0] payload(input int tag, input int ch);
    return {32'hA5A5_0000 + 32'(tag), 32'(ch)};
  endfunction

  initial begin
    vec_t e;
    reset = 1'b1;
    bus.in_valid = '0;
    bus.in_multibeat = '0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

`ifdef LRR_ARB_OUT_REG_EN
    begin
      int exp_q[$];
      int fires;
      fires = 0;
      reset = 1'b0;
      bus.in_valid = 4'hF;
      for (int i = 0; i < N_IN; i++) bus.in_data[i*DATA_W +: DATA_W] = payload(100, i);
      for (int k = 0; k < 16; k++) exp_q.push_back(k % 4);
      for (int c = 0; c < 20; c++) begin
        bus.out_ready = (c % 2 == 0);
        @(negedge clk);
        if (bus.out_valid && bus.out_ready) begin
          int x;
          x = exp_q.pop_front();
          chk($sformatf("reg chosen beat %0d", fires), 64'(bus.out_chosen), 64'(x));
          chk($sformatf("reg data beat %0d", fires), bus.out_data, payload(100, x));
          fires++;
        end
        @(posedge clk);
        #1;
      end
      chk("reg fire count", 64'(fires), 64'd9);
    end
`else
    // reset state, all-invalid parking on N_IN-1
    add(1, 4'b0000, 4'b0000, 1, 2'd3, 0, 0);
    // all valid, single beat: 0,1,2,3,0
    for (int i = 0; i < 5; i++) add(0, 4'b1111, 4'b0000, 1, 2'(i % 4), 1, 0);
    // sparse 0101 from last_grant 0: 2,0,2
    add(0, 4'b0101, 4'b0000, 1, 2'd2, 1, 0);
    add(0, 4'b0101, 4'b0000, 1, 2'd0, 1, 0);
    add(0, 4'b0101, 4'b0000, 1, 2'd2, 1, 0);
    // channel 1 burst of 8 with others valid, then channel 2
    add(0, 4'b0010, 4'b0010, 1, 2'd1, 1, 0);
    for (int i = 0; i < 7; i++) add(0, 4'b1111, 4'b0010, 1, 2'd1, 1, 1);
    add(0, 4'b1111, 4'b0000, 1, 2'd2, 1, 0);
    // burst with a 3-cycle gap on channel 1
    add(0, 4'b0010, 4'b0010, 1, 2'd1, 1, 0);
    for (int i = 0; i < 2; i++) add(0, 4'b1111, 4'b0010, 1, 2'd1, 1, 1);
    for (int i = 0; i < 3; i++) add(0, 4'b1101, 4'b0010, 1, 2'd1, 0, 1);
    for (int i = 0; i < 5; i++) add(0, 4'b1111, 4'b0010, 1, 2'd1, 1, 1);
    add(0, 4'b1111, 4'b0000, 1, 2'd2, 1, 0);
    // reset after beat 4 of a burst
    add(0, 4'b0010, 4'b0010, 1, 2'd1, 1, 0);
    for (int i = 0; i < 3; i++) add(0, 4'b1111, 4'b0010, 1, 2'd1, 1, 1);
    add(1, 4'b1111, 4'b0010, 1, 2'd1, 1, 1);
    add(0, 4'b1111, 4'b0000, 1, 2'd0, 1, 0);
    // flag-low beat mid-burst does not advance the count
    add(0, 4'b0010, 4'b0010, 1, 2'd1, 1, 0);
    add(0, 4'b1111, 4'b0000, 1, 2'd1, 1, 1);
    for (int i = 0; i < 7; i++) add(0, 4'b1111, 4'b0010, 1, 2'd1, 1, 1);
    add(0, 4'b1111, 4'b0000, 1, 2'd2, 1, 0);
    // backpressure: no ready, no grant advance
    add(0, 4'b1111, 4'b0000, 0, 2'd3, 1, 0);
    add(0, 4'b1111, 4'b0000, 1, 2'd3, 1, 0);
    add(0, 4'b0000, 4'b0000, 1, 2'd3, 0, 0);

    foreach (vecs[k]) begin
      reset = vecs[k].rst;
      bus.in_valid = vecs[k].vld;
      bus.in_multibeat = vecs[k].mb;
      bus.out_ready = vecs[k].rdy;
      for (int i = 0; i < N_IN; i++) bus.in_data[i*DATA_W +: DATA_W] = payload(k, i);
      sb.push_back(vecs[k]);
      @(negedge clk);
      e = sb.pop_front();
      chk($sformatf("v%0d chosen", k), 64'(bus.out_chosen), 64'(e.ch));
      chk($sformatf("v%0d valid", k), 64'(bus.out_valid), 64'(e.v));
      chk($sformatf("v%0d in_ready", k), 64'(bus.in_ready), 64'(e.rexp));
      chk($sformatf("v%0d locked", k), 64'(bus.out_locked), 64'(e.lk));
      chk($sformatf("v%0d data", k), bus.out_data, payload(k, int'(e.ch)));
      chk($sformatf("v%0d multibeat", k), 64'(bus.out_multibeat), 64'(e.mb[e.ch]));
      @(posedge clk);
      #1;
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
